// File: rtl/reg_nbit_univ.sv
// WIDTH-bit universal register: load, shift, rotate and up/down count, with a
// start/busy/done handshake that repeats one operation for a programmed number of clocks.
module reg_nbit_univ #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state;
  op_e               op_r;
  logic [STEP_W-1:0] rem;

  op_e               sel_op;
  logic              apply;
  logic [WIDTH-1:0]  q_nxt;
  logic              sout_nxt;
  logic              wrap;

  // A run keeps using the latched op; in IDLE the live mode input selects it.
  assign sel_op = (state == RUN) ? op_r : op_e'(mode);
  assign apply  = (state == RUN) ||
                  (start && (steps != '0)) ||
                  (!start && en);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    q_nxt    = q;
    sout_nxt = sout;
    wrap     = 1'b0;
    unique case (sel_op)
      OP_HOLD: ;
      OP_LOAD: q_nxt = d;
      OP_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      OP_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      OP_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      OP_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      OP_INC: begin
        q_nxt = q + WIDTH'(1);
        wrap  = &q;
      end
      OP_DEC: begin
        q_nxt = q - WIDTH'(1);
        wrap  = ~|q;
      end
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      op_r  <= OP_HOLD;
      rem   <= '0;
      q     <= '0;
      sout  <= 1'b0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      tc   <= apply && wrap;
      if (apply) begin
        q    <= q_nxt;
        sout <= sout_nxt;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (steps <= STEP_W'(1)) begin
              done <= 1'b1;
            end else begin
              op_r  <= op_e'(mode);
              rem   <= steps - STEP_W'(1);
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= rem - STEP_W'(1);
          if (rem == STEP_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_nbit_univ.sv
// Self-checking bench for reg_nbit_univ: directed scenarios plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_reg_nbit_univ;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          clear, en, sin, start;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [SW-1:0] steps;
  logic [W-1:0]  q;
  logic          sout, tc, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: value, flags and how many steps of a run remain.
  int m_q, m_sout, m_tc, m_busy, m_done, m_left, m_op;

  reg_nbit_univ #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .steps(steps), .q(q), .sout(sout), .tc(tc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_op(input int op);
    case (op)
      1: m_q = int'(d);
      2: begin m_sout = m_q / (M / 2); m_q = (m_q * 2) % M + int'(sin); end
      3: begin m_sout = m_q % 2; m_q = m_q / 2 + int'(sin) * (M / 2); end
      4: begin m_sout = m_q / (M / 2); m_q = (m_q * 2) % M + m_sout; end
      5: begin m_sout = m_q % 2; m_q = m_q / 2 + m_sout * (M / 2); end
      6: begin m_tc = (m_q == M - 1); m_q = (m_q + 1) % M; end
      7: begin m_tc = (m_q == 0); m_q = (m_q + M - 1) % M; end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    m_tc   = 0;
    m_done = 0;
    if (clear) begin
      m_q = 0; m_sout = 0; m_busy = 0; m_left = 0;
    end else if (m_left > 0) begin
      model_op(m_op);
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
    end else if (start) begin
      if (steps == 0) m_done = 1;
      else begin
        model_op(int'(mode));
        if (steps == 1) m_done = 1;
        else begin m_op = int'(mode); m_left = int'(steps) - 1; m_busy = 1; end
      end
    end else if (en) begin
      model_op(int'(mode));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("q", int'(q), m_q);
    check("sout", int'(sout), m_sout);
    check("tc", int'(tc), m_tc);
    check("busy", int'(busy), m_busy);
    check("done", int'(done), m_done);
    check("done_and_busy", int'(done && busy), 0);
  endtask

  task automatic drive(input logic c, input logic e, input logic [2:0] md,
                       input logic [W-1:0] dv, input logic s, input logic st,
                       input logic [SW-1:0] n);
    clear = c; en = e; mode = md; d = dv; sin = s; start = st; steps = n;
  endtask

  task automatic idle();
    drive(0, 0, 3'b000, '0, 0, 0, '0);
  endtask

  initial begin
    drive(1, 0, 3'b000, '0, 0, 0, '0);
    m_q = 0; m_sout = 0; m_tc = 0; m_busy = 0; m_done = 0; m_left = 0; m_op = 0;
    #2;

    // 1: reset, then parallel load
    tick();
    check("t1_reset_q", int'(q), 0);
    check("t1_reset_busy", int'(busy), 0);
    drive(0, 1, 3'b001, 8'hA5, 0, 0, '0); tick();
    check("t1_load", int'(q), 'hA5);

    // 2: three-step rotate-left run from 0x81
    drive(0, 1, 3'b001, 8'h81, 0, 0, '0); tick();
    drive(0, 0, 3'b100, '0, 0, 1, 4'd3); tick();
    check("t2_s1_q", int'(q), 'h03); check("t2_s1_sout", int'(sout), 1);
    check("t2_s1_busy", int'(busy), 1);
    idle(); tick();
    check("t2_s2_q", int'(q), 'h06); check("t2_s2_busy", int'(busy), 1);
    tick();
    check("t2_s3_q", int'(q), 'h0C); check("t2_s3_done", int'(done), 1);
    check("t2_s3_busy", int'(busy), 0);
    tick();
    check("t2_done_drop", int'(done), 0);

    // 3: increment wrap and decrement wrap flag tc
    drive(0, 1, 3'b001, 8'hFE, 0, 0, '0); tick();
    drive(0, 1, 3'b110, '0, 0, 0, '0); tick();
    check("t3_inc1_q", int'(q), 'hFF); check("t3_inc1_tc", int'(tc), 0);
    tick();
    check("t3_inc2_q", int'(q), 'h00); check("t3_inc2_tc", int'(tc), 1);
    idle(); tick();
    check("t3_tc_drop", int'(tc), 0);
    drive(0, 1, 3'b111, '0, 0, 0, '0); tick();
    check("t3_dec_q", int'(q), 'hFF); check("t3_dec_tc", int'(tc), 1);

    // 4: shift right with sin=1, then shift left with sin=0
    drive(0, 1, 3'b001, 8'h0F, 0, 0, '0); tick();
    drive(0, 1, 3'b011, '0, 1, 0, '0); tick();
    check("t4_shr_q", int'(q), 'h87); check("t4_shr_sout", int'(sout), 1);
    drive(0, 1, 3'b010, '0, 0, 0, '0); tick();
    check("t4_shl_q", int'(q), 'h0E); check("t4_shl_sout", int'(sout), 1);

    // 5: clear aborts a run without a done pulse
    drive(0, 1, 3'b001, 8'h01, 0, 0, '0); tick();
    drive(0, 0, 3'b101, '0, 0, 1, 4'd5); tick();
    idle(); tick();
    drive(1, 0, 3'b000, '0, 0, 0, '0); tick();
    check("t5_abort_q", int'(q), 0); check("t5_abort_busy", int'(busy), 0);
    idle(); tick();
    check("t5_no_done", int'(done), 0);
    drive(0, 1, 3'b001, 8'h3C, 0, 0, '0); tick();
    check("t5_after_load", int'(q), 'h3C);

    // 6: en/start ignored while busy; zero-step start only pulses done
    drive(0, 0, 3'b110, '0, 0, 1, 4'd4); tick();
    drive(0, 1, 3'b001, 8'h55, 0, 1, 4'd2); tick(); tick();
    idle(); tick();
    check("t6_run_q", int'(q), 'h40); check("t6_run_done", int'(done), 1);
    drive(0, 0, 3'b110, '0, 0, 1, 4'd0); tick();
    check("t6_zero_q", int'(q), 'h40); check("t6_zero_done", int'(done), 1);
    check("t6_zero_busy", int'(busy), 0);
    idle(); tick();
    check("t6_zero_drop", int'(done), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), $urandom_range(1), 3'($urandom_range(7)),
            W'($urandom), $urandom_range(1), ($urandom_range(7) == 0),
            SW'($urandom_range(15)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
